// File: rtl/sort_scheduler.sv
// sort_scheduler: shares one pipelined sort engine (latency NUM_VALS) among
// NUM_REQ requesters. Round-robin arbitration, issue register plus a tag
// pipeline carrying the requester id, result FIFO draining to a valid/ready
// response port, and an occupancy credit that keeps the FIFO from overflowing.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       per-requester handshake (req_ready is one-hot)
//   req_data                  requester i at slice i*NUM_VALS*SIZE
//   sort_data/sort_valid      issue to the sort engine
//   sort_sorted/sort_done     result from the sort engine
//   resp_valid/ready/data/id  response port (head of result FIFO)
//   err_tag                   sticky: engine result and tag pipeline disagreed
//   busy                      vectors outstanding anywhere in the scheduler
//
// Optional feature: define SORT_SCHED_PERF_EN to add perf_clear, perf_issued
// and perf_stall (saturating 32-bit issue and credit-stall counters).
module sort_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned NUM_VALS   = 5,
   parameter int unsigned SIZE       = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int unsigned VEC_W     = NUM_VALS * SIZE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*VEC_W-1:0]   req_data,
   output logic [VEC_W-1:0]           sort_data,
   output logic                       sort_valid,
   input  logic [VEC_W-1:0]           sort_sorted,
   input  logic                       sort_done,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [VEC_W-1:0]           resp_data,
   output logic [IDW-1:0]             resp_id,
   output logic                       err_tag,
   output logic                       busy
`ifdef SORT_SCHED_PERF_EN
   ,
   input  logic                       perf_clear,
   output logic [31:0]                perf_issued,
   output logic [31:0]                perf_stall
`endif
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     gnt_id;
   logic [IDW-1:0]     cand;
   logic               found;
   logic [NUM_REQ-1:0] gnt;
   logic [VEC_W-1:0]   req_vec [NUM_REQ];
   logic [VEC_W-1:0]   gnt_data;
   logic [CW-1:0]      inflight;
   logic               credit_ok;
   logic               accept;
   logic               pop;
   logic               push;

   logic [NUM_VALS:0]  tag_v;
   logic [IDW-1:0]     tag_id [NUM_VALS+1];

   logic [VEC_W-1:0]   fifo_data [FIFO_DEPTH];
   logic [IDW-1:0]     fifo_id   [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;

   // Unpack the flat request bus
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_vec[i] = req_data[i*VEC_W +: VEC_W];
      end
   end

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      cand   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDW'((32'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            gnt_id = cand;
         end
      end
      gnt      = found ? (NUM_REQ'(1) << gnt_id) : '0;
      gnt_data = req_vec[gnt_id];
   end

   // Credit uses registered occupancy only; no path from resp_ready
   assign credit_ok = (inflight != CW'(FIFO_DEPTH));
   assign req_ready = (rst || !credit_ok) ? '0 : gnt;
   assign accept    = |(req_valid & req_ready);
   assign pop       = resp_valid & resp_ready;
   assign push      = sort_done & tag_v[NUM_VALS];
   assign busy      = (inflight != '0);

   // Arbitration pointer and occupancy counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         inflight <= '0;
      end else begin
         if (accept) begin
            rr_ptr <= IDW'((32'(gnt_id) + 32'd1) % NUM_REQ);
         end
         case ({accept, pop})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Issue register and tag pipeline; tag_v[NUM_VALS] lines up with sort_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sort_valid <= 1'b0;
         sort_data  <= '0;
         tag_v      <= '0;
         for (int unsigned k = 0; k <= NUM_VALS; k++) begin
            tag_id[k] <= '0;
         end
      end else begin
         sort_valid <= accept;
         if (accept) begin
            sort_data <= gnt_data;
         end
         tag_v     <= {tag_v[NUM_VALS-1:0], accept};
         tag_id[0] <= gnt_id;
         for (int unsigned k = 1; k <= NUM_VALS; k++) begin
            tag_id[k] <= tag_id[k-1];
         end
      end
   end

   // Sticky error when engine done and tag validity disagree
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_tag <= 1'b0;
      end else if (sort_done != tag_v[NUM_VALS]) begin
         err_tag <= 1'b1;
      end
   end

   // FIFO storage (not reset; outputs are masked while empty)
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= sort_sorted;
         fifo_id[wr_ptr]   <= tag_id[NUM_VALS];
      end
   end

   // FIFO pointers and occupancy; push+pop together leaves count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign resp_valid = (count != '0);
   assign resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;
   assign resp_id    = resp_valid ? fifo_id[rd_ptr]   : '0;

`ifdef SORT_SCHED_PERF_EN
   // Saturating issue and credit-stall counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else if (perf_clear) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (accept && (perf_issued != '1)) begin
            perf_issued <= perf_issued + 32'd1;
         end
         if ((|req_valid) && !credit_ok && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sort_scheduler.sv
// Testbench for sort_scheduler: behavioural sort engine, scoreboard of
// expected responses filled at accept time and drained at response pops.
module tb_sort_scheduler;

   localparam int unsigned NR  = 4;
   localparam int unsigned NV  = 5;
   localparam int unsigned SZ  = 16;
   localparam int unsigned FD  = 8;
   localparam int unsigned IDW = 2;
   localparam int unsigned VW  = NV * SZ;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*VW-1:0]  req_data;
   logic [VW-1:0]     rq [NR];
   logic [VW-1:0]     sort_data;
   logic              sort_valid;
   logic [VW-1:0]     sort_sorted;
   logic              sort_done;
   logic              resp_valid;
   logic              resp_ready;
   logic [VW-1:0]     resp_data;
   logic [IDW-1:0]    resp_id;
   logic              err_tag;
   logic              busy;
   logic              inj_done;
`ifdef SORT_SCHED_PERF_EN
   logic [31:0]       perf_issued;
   logic [31:0]       perf_stall;
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NR; g++) begin : g_pack
      assign req_data[g*VW +: VW] = rq[g];
   end

   sort_scheduler #(.NUM_REQ(NR), .NUM_VALS(NV), .SIZE(SZ), .FIFO_DEPTH(FD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_data    (req_data),
      .sort_data   (sort_data),
      .sort_valid  (sort_valid),
      .sort_sorted (sort_sorted),
      .sort_done   (sort_done),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_id     (resp_id),
      .err_tag     (err_tag),
      .busy        (busy)
`ifdef SORT_SCHED_PERF_EN
      ,
      .perf_clear  (1'b0),
      .perf_issued (perf_issued),
      .perf_stall  (perf_stall)
`endif
   );

   // Ascending sort, smallest value in the least significant slot
   function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
      logic [SZ-1:0] a [NV];
      logic [SZ-1:0] t;
      logic [VW-1:0] r;
      for (int i = 0; i < NV; i++) a[i] = v[i*SZ +: SZ];
      for (int i = 0; i < NV - 1; i++) begin
         for (int j = 0; j < NV - 1 - i; j++) begin
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      r = '0;
      for (int i = 0; i < NV; i++) r[i*SZ +: SZ] = a[i];
      return r;
   endfunction

   // Behavioural engine: NV-cycle pipeline, cleared by the same reset
   logic [NV-1:0] ev;
   logic [VW-1:0] ed [NV];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ev <= '0;
      else     ev <= {ev[NV-2:0], sort_valid};
   end
   always_ff @(posedge clk) begin
      ed[0] <= sort_vec(sort_data);
      for (int k = 1; k < NV; k++) ed[k] <= ed[k-1];
   end
   assign sort_done   = ev[NV-1] | inj_done;
   assign sort_sorted = ed[NV-1];

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [VW-1:0]  data;
   } exp_t;

   exp_t            sb [$];
   exp_t            e;
   logic [IDW-1:0]  m_rr;
   int              m_infl;
   bit              mon_en = 1'b0;
   bit              chk_err = 1'b1;
   logic            prev_v, prev_r;
   logic [VW-1:0]   prev_d;
   logic [IDW-1:0]  prev_id;
   logic [NR-1:0]   eg;
   logic [IDW-1:0]  gid;

   function automatic logic [NR-1:0] exp_grant(input logic [NR-1:0] v, input logic [IDW-1:0] rr,
                                                input int infl);
      int idx;
      if (infl >= int'(FD)) return '0;
      for (int k = 0; k < NR; k++) begin
         idx = (int'(rr) + k) % NR;
         if (v[idx]) return NR'(1) << idx;
      end
      return '0;
   endfunction

   // Monitor: grant/credit model, scoreboard push on accept, pop on response
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_rr   = '0;
         m_infl = 0;
         prev_v = 1'b0;
         prev_r = 1'b0;
      end else if (mon_en) begin
         eg = exp_grant(req_valid, m_rr, m_infl);
         check_eq("req_ready", VW'(req_ready), VW'(eg));
         check_eq("busy", VW'(busy), VW'(m_infl != 0));
         if (chk_err) check_eq("err_tag_clear", VW'(err_tag), '0);
         if (prev_v && !prev_r) begin
            check_eq("hold_valid", VW'(resp_valid), VW'(1));
            check_eq("hold_data", resp_data, prev_d);
            check_eq("hold_id", VW'(resp_id), VW'(prev_id));
         end
         if (|eg) begin
            gid = '0;
            for (int i = 0; i < NR; i++) if (eg[i]) gid = IDW'(i);
            sb.push_back('{id: gid, data: sort_vec(rq[gid])});
            m_rr = IDW'((int'(gid) + 1) % NR);
            m_infl++;
         end
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               check_eq("resp_unexpected", VW'(1), VW'(0));
            end else begin
               e = sb.pop_front();
               check_eq("resp_id", VW'(resp_id), VW'(e.id));
               check_eq("resp_data", resp_data, e.data);
            end
            m_infl--;
         end
         prev_v  = resp_valid;
         prev_r  = resp_ready;
         prev_d  = resp_data;
         prev_id = resp_id;
      end
   end

   // Called just after a posedge; returns just after the posedge releasing reset
   task automatic do_reset();
      rst = 1'b1;
      req_valid = '1;
      @(negedge clk);
      check_eq("rst_req_ready", VW'(req_ready), '0);
      check_eq("rst_sort_valid", VW'(sort_valid), '0);
      check_eq("rst_sort_data", sort_data, '0);
      check_eq("rst_resp_valid", VW'(resp_valid), '0);
      check_eq("rst_resp_data", resp_data, '0);
      check_eq("rst_resp_id", VW'(resp_id), '0);
      check_eq("rst_err_tag", VW'(err_tag), '0);
      check_eq("rst_busy", VW'(busy), '0);
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b0;
   endtask

   task automatic drain();
      int c;
      c = 0;
      resp_ready = 1'b1;
      while ((sb.size() != 0 || resp_valid) && c < 300) begin
         @(negedge clk);
         c++;
      end
      check_eq("drain_done", VW'(sb.size()), '0);
   endtask

   task automatic single_req(input int id, input logic [VW-1:0] d, input logic [VW-1:0] exp);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      rq[id] = d;
      req_valid = NR'(1) << id;
      @(negedge clk);
      check_eq("single_grant", VW'(req_ready), VW'(NR'(1) << id));
      @(posedge clk); #1;
      req_valid = '0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) check_eq("single_issue", VW'(sort_valid), VW'(1));
         if (k == 6) check_eq("single_early", VW'(resp_valid), VW'(0));
         if (k == 7) begin
            check_eq("single_valid", VW'(resp_valid), VW'(1));
            check_eq("single_id", VW'(resp_id), VW'(id));
            check_eq("single_data", resp_data, exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end

   initial begin
      int n_acc;
      logic [VW-1:0] d;
      req_valid  = '0;
      resp_ready = 1'b1;
      inj_done   = 1'b0;
      for (int i = 0; i < NR; i++) rq[i] = '0;

      @(posedge clk); #1;
      do_reset();
      mon_en = 1'b1;

      // Round-robin with all requesters valid
      @(posedge clk); #1;
      req_valid = '1;
      for (int i = 0; i < NR; i++) rq[i] = VW'({$urandom(), $urandom(), $urandom()});
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("rr_grant", VW'(req_ready), VW'(NR'(1) << (i % NR)));
         @(posedge clk); #1;
         for (int j = 0; j < NR; j++) rq[j] = VW'({$urandom(), $urandom(), $urandom()});
      end
      req_valid = '0;
      drain();

      // Single request with a known vector
      single_req(0, {16'd1, 16'd5, 16'd3, 16'd2, 16'd4}, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
      drain();

      // Backpressure: requester 2 streams into a stalled consumer
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 4'b0100;
      n_acc = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready[2]) n_acc++;
         @(posedge clk); #1;
         rq[2] = VW'({$urandom(), $urandom(), $urandom()});
      end
      check_eq("bp_accepts", VW'(n_acc), VW'(FD));
      @(negedge clk);
      check_eq("bp_credit_out", VW'(req_ready), '0);
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_same_cycle", VW'(req_ready), '0);
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check_eq("bp_after_pop", VW'(req_ready), VW'(4'b0100));
      // Pop coincides with the push of that vector while credit is exhausted
      repeat (6) begin
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check_eq("sim_push", VW'(sort_done), VW'(1));
      check_eq("sim_pop", VW'(resp_valid), VW'(1));
      check_eq("sim_credit", VW'(req_ready), '0);
      @(posedge clk); #1;
      req_valid = '0;
      drain();

      // Reset with 2 results queued and 3 in the engine
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 4'b0010;
      repeat (5) begin
         rq[1] = VW'({$urandom(), $urandom(), $urandom()});
         @(posedge clk); #1;
      end
      req_valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("mid_fifo_valid", VW'(resp_valid), VW'(1));
      @(posedge clk); #1;
      do_reset();
      d = VW'({$urandom(), $urandom(), $urandom()});
      single_req(3, d, sort_vec(d));
      drain();

      // Engine done with no issued tag
      @(posedge clk); #1;
      chk_err  = 1'b0;
      inj_done = 1'b1;
      @(posedge clk); #1;
      inj_done = 1'b0;
      @(negedge clk);
      check_eq("err_set", VW'(err_tag), VW'(1));
      check_eq("err_fifo_empty", VW'(resp_valid), '0);
      repeat (5) @(negedge clk);
      check_eq("err_sticky", VW'(err_tag), VW'(1));
      check_eq("err_still_empty", VW'(resp_valid), '0);
      check_eq("err_not_busy", VW'(busy), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
